// File: rtl/timer_pkg.sv
// Shared register map, CTRL field positions and FSM state type for the
// memory-mapped interval timer.
package timer_pkg;

    localparam logic [1:0] CTRL_OFS   = 2'b00;
    localparam logic [1:0] PRESET_OFS = 2'b01;
    localparam logic [1:0] COUNT_OFS  = 2'b10;

    localparam int unsigned EN_BIT   = 0;
    localparam int unsigned MODE_LSB = 1;
    localparam int unsigned MODE_MSB = 2;
    localparam int unsigned IM_BIT   = 3;

    // Encodings 2'b10 and 2'b11 are treated as one-shot.
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_counter.sv
// 32-bit down-counting timer with one-shot / auto-reload modes, a maskable
// level interrupt and a combinational register read port.
module timer_counter
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    state_t      state;

    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_addr;

    assign ctrl_wr     = WE && (Addr[3:2] == CTRL_OFS);
    assign preset_wr   = WE && (Addr[3:2] == PRESET_OFS);
    assign unused_addr = ^Addr[31:4];

    // CPU register writes follow the FSM case so a CTRL write in the same
    // cycle overrides the FSM clearing EN or setting irq_flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
            state    <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ctrl[EN_BIT]) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[EN_BIT]) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (ctrl[MODE_MSB:MODE_LSB] == MODE_RELOAD) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl[EN_BIT] <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (preset_wr) preset <= Din;
            if (ctrl_wr) begin
                ctrl     <= Din[3:0];
                irq_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = '0;
        unique case (Addr[3:2])
            CTRL_OFS:   Dout = {28'd0, ctrl};
            PRESET_OFS: Dout = preset;
            COUNT_OFS:  Dout = count;
            default:    Dout = '0;
        endcase
    end

    assign IRQ = ctrl[IM_BIT] & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// trials checked against an arithmetic timeline model of the timer.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks;
    int failures;

    localparam logic [29:0] BASE = 30'h1FC0;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ofs, input logic [31:0] data);
        Addr = BASE | {28'd0, ofs};
        WE   = 1'b1;
        Din  = data;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic rd(input logic [1:0] ofs, output logic [31:0] data);
        Addr = BASE | {28'd0, ofs};
        #1;
        data = Dout;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        logic [31:0] d;
        do_reset();
        rd(2'b00, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        rd(2'b01, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_preset got=%h exp=0", d); end
        rd(2'b10, d); checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin failures++; $display("FAIL reset_count got=%h irq=%b exp=0/0", d, IRQ); end
        wr(2'b01, 32'd10);
        wr(2'b00, 32'h9);
        repeat (5) tick();
        rd(2'b10, d); checks++;
        if (d !== 32'd7) begin failures++; $display("FAIL reset_precount got=%0d exp=7", d); end
        #1 reset = 1'b0;
        #1;
        rd(2'b10, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_async_count got=%0d exp=0", d); end
        rd(2'b00, d); checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin failures++; $display("FAIL reset_async_ctrl got=%h irq=%b exp=0/0", d, IRQ); end
        reset = 1'b1;
        repeat (4) tick();
        rd(2'b10, d); checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin failures++; $display("FAIL reset_stays_idle count=%0d irq=%b exp=0/0", d, IRQ); end
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        do_reset();
        wr(2'b01, 32'd5);
        Addr = BASE | 30'd0; WE = 1'b1; Din = 32'h9;
        #1; checks++;
        if (Dout !== 32'd0) begin failures++; $display("FAIL read_during_write got=%h exp=0", Dout); end
        tick(); WE = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick(); checks++;
            if (IRQ !== (e >= 7)) begin failures++; $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", e, IRQ, e >= 7); end
        end
        tick();
        rd(2'b00, d); checks++;
        if (d !== 32'h8 || IRQ !== 1'b1) begin failures++; $display("FAIL oneshot_ctrl got=%h irq=%b exp=8/1", d, IRQ); end
        rd(2'b10, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL oneshot_count got=%0d exp=0", d); end
        wr(2'b00, 32'h8); checks++;
        if (IRQ !== 1'b0) begin failures++; $display("FAIL oneshot_ack got=%b exp=0", IRQ); end
    endtask

    task automatic test_autoreload;
        logic [31:0] d;
        int p;
        logic [31:0] exp_cnt;
        do_reset();
        wr(2'b01, 32'd3);
        wr(2'b00, 32'hB);
        for (int e = 1; e <= 20; e++) begin
            tick(); checks++;
            if (IRQ !== (e >= 5 && (e - 5) % 5 == 0)) begin
                failures++; $display("FAIL reload_irq edge=%0d got=%b", e, IRQ);
            end
            if (e >= 2) begin
                p = (e - 2) % 5;
                exp_cnt = (p == 0) ? 32'd3 : (p < 3) ? 32'(3 - p) : 32'd0;
                rd(2'b10, d); checks++;
                if (d !== exp_cnt) begin failures++; $display("FAIL reload_count edge=%0d got=%0d exp=%0d", e, d, exp_cnt); end
            end
        end
    endtask

    task automatic test_irq_mask;
        int seen;
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h3);
        for (int e = 1; e <= 12; e++) begin
            tick(); checks++;
            if (IRQ !== 1'b0) begin failures++; $display("FAIL mask_irq edge=%0d got=%b exp=0", e, IRQ); end
        end
        wr(2'b00, 32'hB);
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            if (IRQ === 1'b1) seen = 1; else tick();
        end
        checks++;
        if (seen == 0) begin failures++; $display("FAIL unmask_irq timeout got=0 exp=1"); end
        tick(); checks++;
        if (IRQ !== 1'b0) begin failures++; $display("FAIL unmask_pulse got=%b exp=0", IRQ); end
        do_reset();
        wr(2'b01, 32'd2);
        wr(2'b00, 32'h1);
        repeat (8) tick();
        wr(2'b00, 32'h8); checks++;
        if (IRQ !== 1'b0) begin failures++; $display("FAIL flag_clear got=%b exp=0", IRQ); end
    endtask

    task automatic test_preset_midcount;
        logic [31:0] d;
        int found;
        do_reset();
        wr(2'b01, 32'd100);
        wr(2'b00, 32'h3);
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            rd(2'b10, d);
            if (d == 32'd50) found = 1; else tick();
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL wait_count50 timeout got=%0d exp=50", d); end
        wr(2'b01, 32'd4);
        rd(2'b10, d); checks++;
        if (d !== 32'd49) begin failures++; $display("FAIL preset_no_disturb got=%0d exp=49", d); end
        wr(2'b10, 32'd777);
        wr(2'b11, 32'd555);
        rd(2'b10, d); checks++;
        if (d !== 32'd47) begin failures++; $display("FAIL count_ro got=%0d exp=47", d); end
        rd(2'b11, d); checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL ofs3_read got=%h exp=0", d); end
        rd(2'b01, d); checks++;
        if (d !== 32'd4) begin failures++; $display("FAIL preset_read got=%0d exp=4", d); end
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            rd(2'b10, d);
            if (d == 32'd1) found = 1; else tick();
        end
        checks++;
        if (found == 0) begin failures++; $display("FAIL wait_count1 timeout got=%0d exp=1", d); end
        repeat (3) tick();
        rd(2'b10, d); checks++;
        if (d !== 32'd4) begin failures++; $display("FAIL reload_new_preset got=%0d exp=4", d); end
    endtask

    task automatic test_preset_zero;
        logic [31:0] d;
        do_reset();
        wr(2'b01, 32'd0);
        wr(2'b00, 32'h9);
        for (int e = 1; e <= 3; e++) begin
            tick(); checks++;
            if (IRQ !== (e == 3)) begin failures++; $display("FAIL zero_irq edge=%0d got=%b exp=%b", e, IRQ, e == 3); end
        end
        wr(2'b00, 32'h5);
        rd(2'b00, d); checks++;
        if (d !== 32'h5 || IRQ !== 1'b0) begin failures++; $display("FAIL coincident_write ctrl=%h irq=%b exp=5/0", d, IRQ); end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [31:0] n, nn, exp_cnt, exp_ctrl, v;
        logic        rl, im, exp_irq;
        int          p, len;
        for (int t = 0; t < 12; t++) begin
            n  = 32'($urandom_range(0, 9));
            nn = (n == 0) ? 32'd1 : n;
            v  = {28'd0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            rl = (v[2:1] == 2'b01);
            im = v[3];
            do_reset();
            wr(2'b01, n);
            wr(2'b00, v);
            tick();
            rd(2'b10, d); checks++;
            if (d !== 32'd0 || IRQ !== 1'b0) begin failures++; $display("FAIL rand_load_cycle t=%0d count=%0d irq=%b exp=0/0", t, d, IRQ); end
            len = 3 * int'(nn + 2) + 3;
            for (int j = 0; j < len; j++) begin
                tick();
                p = rl ? j % int'(nn + 2) : j;
                if (p == 0) exp_cnt = n;
                else if (p < int'(nn)) exp_cnt = nn - 32'(p);
                else exp_cnt = 32'd0;
                exp_irq  = im && (rl ? (p == int'(nn)) : (p >= int'(nn)));
                exp_ctrl = (!rl && j >= int'(nn) + 1) ? (v & ~32'd1) : v;
                rd(2'b10, d); checks++;
                if (d !== exp_cnt || IRQ !== exp_irq) begin
                    failures++;
                    $display("FAIL rand_count t=%0d n=%0d ctrl=%h j=%0d count=%0d irq=%b exp=%0d/%b", t, n, v, j, d, IRQ, exp_cnt, exp_irq);
                end
                rd(2'b00, d); checks++;
                if (d !== exp_ctrl) begin failures++; $display("FAIL rand_ctrl t=%0d j=%0d got=%h exp=%h", t, j, d, exp_ctrl); end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; WE = 1'b0; Din = '0; Addr = BASE;
        #1;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_irq_mask();
        test_preset_midcount();
        test_preset_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped 32-bit down-counting timer attached behind the CPU–peripheral bridge at device window 0x0000_7F00–0x0000_7F0F (a second instance sits at 0x0000_7F10). The bridge supplies the word address, write strobe and write data. The timer returns read data combinationally and raises a level interrupt, which the bridge forwards to CP0 as a hardware interrupt line. It is a software-programmable one-shot or auto-reload interval timer with a small FSM.

## Interface
- No parameters; register offsets and CTRL bit positions come from the shared package.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- Addr  in  [31:2]  word address from bridge; only Addr[3:2] decoded (00 CTRL, 01 PRESET, 10 COUNT, 11 unused).
- WE  in  1  write strobe, already qualified by the bridge for this device.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr[3:2].
- IRQ  out  1  interrupt request = CTRL.IM & irq_flag.

## Operation
- CTRL[3:0]: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), bit3 IM. Reads return {28'b0, CTRL[3:0]}; writes store Din[3:0] only.
- PRESET: 32-bit read/write; a write never disturbs a count in progress; it takes effect at the next LOAD.
- COUNT: read-only; writes ignored. Offset 11: reads 0, writes ignored.
- Any write to CTRL clears irq_flag.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE (COUNT frozen). Else if COUNT > 1, COUNT decrements. Else (COUNT is 0 or 1) COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, MODE 01: irq_flag <= 0; go to LOAD.
  - INT, MODE 00: EN <= 0; go to IDLE; irq_flag holds until the next CTRL write.
- Simultaneous events: a CPU write to CTRL in the same cycle as the FSM clearing EN wins. Its written value is stored, and irq_flag is cleared.
- PRESET = 0 behaves as PRESET = 1: the count expires in the first CNT cycle.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so IRQ=0. Dout follows the reset registers.
- Reset mid-count aborts immediately, with no interrupt.

## Timing
- Write is sampled at edge T.
  - EN=1 written at T: IDLE→LOAD at T+1; COUNT=PRESET after T+2.
  - With PRESET=N≥1: COUNT reaches 1 after edge T+N+1; INT is entered and IRQ rises after edge T+N+2.
- Auto-reload: IRQ is high for exactly 1 cycle; the IRQ period is N+2 cycles.
- One-shot: IRQ stays high, with EN read back as 0, until a CTRL write.
- Dout has zero-cycle latency. A read in the same cycle as a write returns the old value.
- Clearing EN during CNT: COUNT stops after that edge; re-enabling restarts through LOAD with a fresh PRESET.

## Structure
- Shared package `timer_pkg`:
  - offset constants CTRL_OFS=2'b00, PRESET_OFS=2'b01, COUNT_OFS=2'b10;
  - CTRL bit indices EN=0, MODE=2:1, IM=3;
  - MODE encodings;
  - 2-bit state typedef/localparams IDLE=0, LOAD=1, CNT=2, INT=3.
- Single module, no sub-modules; register file, FSM and read mux live in one always/assign set.

## Test plan
- Reset held low mid-count with PRESET=10, EN=1 → COUNT=0, CTRL=0, IRQ=0 immediately; release → stays IDLE.
- PRESET=5, write CTRL=0x9 at edge 0 → IRQ=1 after edge 7, COUNT=0, CTRL reads 0x8. Write CTRL=0x8 → IRQ=0 next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM=1) → 1-cycle IRQ pulses every 5 cycles, first after edge 5; COUNT sequence 3,2,1,0,(LOAD)3.
- CTRL=0x3 (IM=0), PRESET=2 → irq_flag sets but IRQ stays 0. Then write CTRL=0xB → irq_flag cleared; the next expiry drives IRQ.
- PRESET=100 running; write PRESET=4 at COUNT=50 → COUNT continues 49…; the next reload loads 4. Write to COUNT and offset 11 → no change; offset 11 reads 0.
- PRESET=0, CTRL=0x9 → IRQ after edge 3. Also issue a CTRL write coincident with the INT→IDLE edge → the written CTRL value is retained.
